// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, status bit positions and FSM states shared by the ALU pipe
package alu_pipe_pkg;

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_PA  = 5'd5;
    localparam logic [4:0] OP_PB  = 5'd6;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_LSR = 5'd9;
    localparam logic [4:0] OP_ASR = 5'd10;

    localparam int ST_ZERO  = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_NEG   = 2;
    localparam int ST_PAR   = 3;
    localparam int ST_CARRY = 4;
    localparam int ST_ILL   = 5;

    typedef enum logic {IDLE, MUL} state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/result handshake bundle between a producer and the ALU pipe
interface alu_pipe_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inputa;
    logic [WIDTH-1:0] inputb;
    logic [7:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [7:0]       status;

    modport master (
        output in_valid, inputa, inputb, mode, out_ready,
        input  in_ready, out_valid, out, status
    );

    modport slave (
        input  in_valid, inputa, inputb, mode, out_ready,
        output in_ready, out_valid, out, status
    );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier retiring one multiplier bit per cycle
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign busy    = cnt != '0;
    assign done    = cnt == CW'(1);
    // product is the accumulator after this cycle's partial product; final when done
    assign product = acc + (mplier[0] ? mcand : '0);

    // load operands on start, then add one shifted partial product per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with shifts, iterative multiply and full status flags
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_pipe_if.slave bus
);

    localparam int SW = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   opa, opb, res, val;
    logic [4:0]         opc;
    logic [SW-1:0]      sh;
    logic [WIDTH:0]     sum, shl_w, shr_w, asr_w;
    logic [7:0]         st_nxt;
    logic               accept, is_mul, mul_start, load;
    logic               ill, carry, ovf;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] product;

    assign opa       = bus.mode[0] ? ~bus.inputa : bus.inputa;
    assign opb       = bus.mode[1] ? ~bus.inputb : bus.inputb;
    assign opc       = bus.mode[7:3];
    assign sh        = opb[SW-1:0];
    assign is_mul    = MUL_EN && opc == OP_MUL;
    assign bus.in_ready = state == IDLE && (!bus.out_valid || bus.out_ready);
    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && is_mul;
    assign load      = (accept && !is_mul) || mul_done;

    assign sum   = {1'b0, opa} + {1'b0, opb} + (WIDTH+1)'(bus.mode[2]);
    // the extra bit on each shift catches the last bit shifted out (0 when sh=0)
    assign shl_w = {1'b0, opa} << sh;
    assign shr_w = {opa, 1'b0} >> sh;
    assign asr_w = $signed({opa, 1'b0}) >>> sh;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (mul_start),
                .a      (opa),
                .b      (opb),
                .busy   (mul_busy),
                .done   (mul_done),
                .product(product)
            );
        end else begin : g_nomul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign product  = '0;
        end
    endgenerate

    // single-cycle datapath: result, carry, overflow and legality per opcode
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        ill   = 1'b0;
        case (opc)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (sum[WIDTH-1] & ~opa[WIDTH-1] & ~opb[WIDTH-1]) |
                        (~sum[WIDTH-1] & opa[WIDTH-1] & opb[WIDTH-1]);
            end
            OP_AND: res = opa & opb;
            OP_OR:  res = opa | opb;
            OP_XOR: res = opa ^ opb;
            OP_PA:  res = opa;
            OP_PB:  res = opb;
            OP_MUL: ill = !MUL_EN;
            OP_SHL: begin
                res   = shl_w[WIDTH-1:0];
                carry = shl_w[WIDTH];
            end
            OP_LSR: begin
                res   = shr_w[WIDTH:1];
                carry = shr_w[0];
            end
            OP_ASR: begin
                res   = asr_w[WIDTH:1];
                carry = asr_w[0];
            end
            default: ill = 1'b1;
        endcase
    end

    // flags are derived from whichever result is about to be registered
    always_comb begin
        val              = mul_done ? product[WIDTH-1:0] : res;
        st_nxt           = '0;
        st_nxt[ST_ZERO]  = ~|val;
        st_nxt[ST_OVF]   = !mul_done && ovf;
        st_nxt[ST_NEG]   = val[WIDTH-1];
        st_nxt[ST_PAR]   = ~^val;
        st_nxt[ST_CARRY] = mul_done ? |product[2*WIDTH-1:WIDTH] : carry;
        st_nxt[ST_ILL]   = !mul_done && ill;
    end

    // next state: enter MUL on a multiply accept, leave when the multiplier finishes
    always_comb begin
        state_nxt = state == IDLE ? (mul_start ? MUL : IDLE)
                                  : ((mul_done || !mul_busy) ? IDLE : MUL);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // result register: load wins over a same-edge consume so throughput stays 1/cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.status    <= '0;
            bus.out_valid <= 1'b0;
        end else if (load) begin
            bus.out       <= val;
            bus.status    <= st_nxt;
            bus.out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with a scoreboard checking result, flags and latency
module tb_alu_pipe;

    typedef struct {
        logic [7:0] o;
        logic [7:0] s;
        int         due;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;
    exp_t q[$];
    exp_t q2[$];

    alu_pipe_if #(.WIDTH(8)) b ();
    alu_pipe_if #(.WIDTH(8)) b2 ();

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b.slave)
    );

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b2.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic issue(input string name, input logic [7:0] a, input logic [7:0] bb,
                         input logic [7:0] m, input logic [7:0] eo, input logic [7:0] es);
        bit ok = 1'b0;
        exp_t e;
        b.in_valid = 1'b1;
        b.inputa   = a;
        b.inputb   = bb;
        b.mode     = m;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (b.in_ready) begin
                e.o = eo;
                e.s = es;
                e.due = cyc + 1 + (m[7:3] == 5'd7 ? 8 : 0);
                e.name = name;
                q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: accept timeout, in_ready stuck at 0, required 1", name);
        end
        @(posedge clk);
        #1 b.in_valid = 1'b0;
    endtask

    // scoreboard monitor: latency on first sight of a result, data on consume
    always @(negedge clk) begin
        if (rst_n && b.out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected result: out=%h status=%h, required no output", b.out, b.status);
            end else begin
                if (!seen) begin
                    checks++;
                    if (cyc != q[0].due) begin
                        errors++;
                        $display("FAIL %s latency: valid at cycle %0d, required %0d", q[0].name, cyc, q[0].due);
                    end
                    seen = 1'b1;
                end
                if (b.out_ready) begin
                    checks++;
                    if (b.out !== q[0].o || b.status !== q[0].s) begin
                        errors++;
                        $display("FAIL %s: out=%h status=%h, required out=%h status=%h",
                                 q[0].name, b.out, b.status, q[0].o, q[0].s);
                    end
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b2.out_valid && b2.out_ready) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL nomul unexpected: out=%h status=%h, required no output", b2.out, b2.status);
            end else begin
                if (b2.out !== q2[0].o || b2.status !== q2[0].s) begin
                    errors++;
                    $display("FAIL %s: out=%h status=%h, required out=%h status=%h",
                             q2[0].name, b2.out, b2.status, q2[0].o, q2[0].s);
                end
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        int bad;
        exp_t e;
        b.in_valid = 1'b0; b.inputa = '0; b.inputb = '0; b.mode = '0; b.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.inputa = '0; b2.inputb = '0; b2.mode = '0; b2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out", 32'(b.out), 32'h00);
        chk("reset status", 32'(b.status), 32'h00);
        chk("reset out_valid", 32'(b.out_valid), 32'h0);
        rst_n = 1'b1;
        #1 chk("in_ready after reset", 32'(b.in_ready), 32'h1);
        @(posedge clk);
        #1;
        // back-to-back single-cycle ops
        issue("add 7f+01", 8'h7F, 8'h01, 8'h08, 8'h80, 8'h06);
        issue("sub 05-05", 8'h05, 8'h05, 8'h0E, 8'h00, 8'h19);
        issue("add ff+01+c", 8'hFF, 8'h01, 8'h0C, 8'h01, 8'h10);
        issue("add 80+80", 8'h80, 8'h80, 8'h08, 8'h00, 8'h1B);
        issue("and", 8'hF0, 8'h3C, 8'h10, 8'h30, 8'h08);
        issue("or", 8'h0F, 8'hF0, 8'h18, 8'hFF, 8'h0C);
        issue("xor", 8'hAA, 8'hFF, 8'h20, 8'h55, 8'h08);
        issue("pass ~a", 8'h0F, 8'h00, 8'h2D, 8'hF0, 8'h0C);
        issue("pass b", 8'h12, 8'h00, 8'h30, 8'h00, 8'h09);
        issue("asr 1", 8'h81, 8'h01, 8'h50, 8'hC0, 8'h1C);
        issue("shl 1", 8'h81, 8'h01, 8'h40, 8'h02, 8'h10);
        issue("lsr 7", 8'h80, 8'h07, 8'h48, 8'h01, 8'h00);
        issue("lsr 0", 8'h81, 8'h08, 8'h48, 8'h81, 8'h0C);
        issue("illegal 31", 8'h12, 8'h34, 8'hF8, 8'h00, 8'h29);
        issue("illegal 0", 8'h12, 8'h34, 8'h00, 8'h00, 8'h29);
        // multiply with in_ready held low for the full iteration
        issue("mul 10*11", 8'h10, 8'h11, 8'h38, 8'h10, 8'h10);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b.in_ready) bad++;
        end
        chk("in_ready low during mul (cycles high)", 32'(bad), 32'h0);
        @(posedge clk);
        #1;
        issue("mul ff*ff", 8'hFF, 8'hFF, 8'h38, 8'h01, 8'h10);
        // reset in the middle of a multiply aborts it
        issue("mul aborted", 8'h10, 8'h11, 8'h38, 8'h10, 8'h10);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        seen = 1'b0;
        #1 chk("out_valid in reset", 32'(b.out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b.out_valid || !b.in_ready) bad++;
        end
        chk("idle after aborted mul (bad cycles)", 32'(bad), 32'h0);
        @(posedge clk);
        #1;
        // backpressure: second op must wait, first result must hold
        b.out_ready = 1'b0;
        issue("add under stall", 8'h01, 8'h02, 8'h08, 8'h03, 8'h08);
        b.in_valid = 1'b1; b.inputa = 8'h3C; b.inputb = 8'h0F; b.mode = 8'h20;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b.in_ready || !b.out_valid || b.out !== 8'h03 || b.status !== 8'h08) bad++;
        end
        chk("stall hold (bad cycles)", 32'(bad), 32'h0);
        @(posedge clk);
        #1 b.out_ready = 1'b1;
        issue("xor after stall", 8'h3C, 8'h0F, 8'h20, 8'h33, 8'h08);
        // multiplier absent: opcode 7 is illegal and completes in one cycle
        b2.in_valid = 1'b1; b2.inputa = 8'h10; b2.inputb = 8'h11; b2.mode = 8'h38;
        @(negedge clk);
        chk("nomul in_ready", 32'(b2.in_ready), 32'h1);
        e.o = 8'h00; e.s = 8'h29; e.due = 0; e.name = "nomul opcode 7";
        q2.push_back(e);
        @(posedge clk);
        #1 b2.in_valid = 1'b0;
        for (int i = 0; i < 50 && (q.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size() + q2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the team's 8-bit single-cycle ALU, for use as an execute unit.
- Keeps the same 8-bit mode word: invert-A, invert-B and carry-in bits, plus an opcode field.
- Adds configurable data width, shifts, and an iterative shift-add multiplier.
- Uses a valid/ready handshake on input and output with backpressure.
- Status flags are fully defined for every operation; no stale flags.

Parameters:
WIDTH, 8, data width of operands and result (>=4, power of two)
MUL_EN, 1, 1 = multiplier present; 0 = opcode 7 is treated as illegal

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request this cycle
inputa  input  WIDTH  operand A
inputb  input  WIDTH  operand B
mode  input  8  [0] invert A, [1] invert B, [2] carry-in, [7:3] opcode
out_valid  output  1  out/status hold a result
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
status  output  8  [0] zero, [1] signed overflow, [2] negative, [3] even parity, [4] carry, [5] illegal op, [7:6] 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - out=0, status=0, out_valid=0, FSM=IDLE, multiplier cleared.
  - in_ready=1 once rst_n is high.
- Operand select: opa = mode[0] ? ~inputa : inputa; opb = mode[1] ? ~inputb : inputb.
- Opcodes:
  - 1 add: {c,r} = opa+opb+mode[2]
  - 2 and
  - 3 or
  - 4 xor
  - 5 pass opa
  - 6 pass opb
  - 7 multiply: low WIDTH bits of unsigned opa*opb
  - 8 shl: opa << sh
  - 9 lsr: opa >> sh
  - 10 asr: opa >>> sh
  - sh = opb[$clog2(WIDTH)-1:0]; mode[2] is ignored for all ops except add.
  - All other opcodes (including 0) are illegal: out=0, status[5]=1.
- Flags, computed on the registered result for every op:
  - status[0] = ~|out; status[2] = out[WIDTH-1]; status[3] = ~^out.
  - status[1]: add only, (r msb & ~opa msb & ~opb msb) | (~r msb & opa msb & opb msb); otherwise 0.
  - status[4]:
    - add: carry-out.
    - multiply: 1 if the upper WIDTH bits of the full product are nonzero.
    - shifts: last bit shifted out (0 when sh=0).
    - otherwise 0.
  - status[5]: 1 only for illegal ops.
- Handshake:
  - Accept occurs on a rising edge when in_valid & in_ready.
  - in_ready = (FSM==IDLE) & (~out_valid | out_ready). This is combinational, with no dependence on in_valid.
  - Inputs are sampled only at accept.
- FSM states IDLE, MUL:
  - IDLE, accept of non-multiply: out/status are registered at the accept edge; out_valid=1 from the next cycle (latency 1).
    - Back-to-back accepts are allowed (throughput 1/cycle) when out_ready=1.
  - IDLE, accept of multiply: load the multiplier; go to MUL with counter=WIDTH.
  - MUL: one partial-product bit per cycle; counter decrements.
    - At the edge where the counter reaches 0, out/status load, out_valid=1, and the FSM returns to IDLE.
    - out_valid is seen WIDTH cycles after the accept edge.
    - in_ready=0 throughout MUL.
- Output side:
  - out_valid clears on the edge where out_ready=1, unless a new result loads on that same edge.
  - out/status stay stable while out_valid=1 and out_ready=0.
  - out/status retain their last value after the handshake; they are don't-care while out_valid=0.
- Reset mid-multiply: the operation is aborted, no result is produced, and the block returns to the reset state.
- Arithmetic is WIDTH-bit, unsigned except for overflow/asr; the full product is 2*WIDTH bits internally.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode constants OP_ADD..OP_ASR;
  - status bit indices ST_ZERO, ST_OVF, ST_NEG, ST_PAR, ST_CARRY, ST_ILL;
  - FSM state enum {IDLE, MUL}.
- Sub-module alu_mul_iter: WIDTH-parametrised shift-add multiplier with start/busy/done and a 2*WIDTH product.
  - alu_pipe owns the handshake and flags.

Test Plan:
1. WIDTH=8, inputa=0x7F, inputb=0x01, mode=0x08 -> next cycle out_valid=1, out=0x80, status=0x06.
2. inputa=0x05, inputb=0x05, mode=0x0E (subtract) -> out=0x00, status=0x19 (zero, even parity, carry).
3. inputa=0x10, inputb=0x11, mode=0x38 (multiply) -> in_ready=0 for 8 cycles, out_valid 8 cycles after accept, out=0x10, status=0x10.
   - Repeat, pulling rst_n low at cycle 4 -> out_valid stays 0, in_ready=1 after release, no result.
4. inputa=0x81, inputb=0x01, mode=0x50 (asr) -> out=0xC0, status=0x1C. Same operands with mode=0x40 (shl) -> out=0x02, status=0x10.
5. mode=0xF8 (opcode 31) -> out=0x00, status=0x29; mode=0x38 with MUL_EN=0 -> status[5]=1.
6. Hold out_ready=0 after an add, with in_valid=1 holding a second op -> in_ready=0, out/status unchanged for 5 cycles. Raise out_ready -> second op accepted on that edge, its result valid next cycle with no bubble.
